// File: rtl/uart_tx_serializer.sv
// UART transmitter: serialises one byte per frame (start, 8 data bits LSB first,
// optional parity, 1 or 2 stop bits) with a registered line output.
module uart_tx_serializer #(
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       system_clock,
    input  logic       rst,
    input  logic       start_uart,
    input  logic [7:0] urt_tx_data,
    output logic       busy_uart,
    output logic       tx,
    output logic       tx_done
);

    localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic              STOP_LAST = (STOP_BITS == 2);
    localparam logic              ODD_FLIP  = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        IDLE,
        START_BIT,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t            state_q, state_d;
    logic [BAUD_W-1:0] baudCnt_q, baudCnt_d;
    logic [2:0]        bitIdx_q, bitIdx_d;
    logic              stopIdx_q, stopIdx_d;
    logic [7:0]        shift_q, shift_d;
    logic              parity_q, parity_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic bitEnd;
    logic lastStop;
    logic frameEnd;
    logic accept;

    assign bitEnd   = (baudCnt_q == BAUD_LAST);
    assign lastStop = (stopIdx_q == STOP_LAST);
    assign frameEnd = (state_q == STOP) && bitEnd && lastStop;
    // A request arriving on the final stop-bit edge is taken immediately so frames abut.
    assign accept   = start_uart && ((state_q == IDLE) || frameEnd);

    always_ff @(posedge system_clock) begin
        if (rst) begin
            state_q   <= IDLE;
            baudCnt_q <= '0;
            bitIdx_q  <= '0;
            stopIdx_q <= 1'b0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            baudCnt_q <= baudCnt_d;
            bitIdx_q  <= bitIdx_d;
            stopIdx_q <= stopIdx_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = START_BIT;
                end
            end
            START_BIT: begin
                if (bitEnd) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bitEnd && (bitIdx_q == 3'd7)) begin
                    state_d = (PARITY_EN != 0) ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (bitEnd) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (frameEnd) begin
                    state_d = accept ? START_BIT : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        baudCnt_d = baudCnt_q;
        bitIdx_d  = bitIdx_q;
        stopIdx_d = stopIdx_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        if (state_q != IDLE) begin
            baudCnt_d = bitEnd ? '0 : baudCnt_q + BAUD_W'(1);
        end

        case (state_q)
            START_BIT: begin
                if (bitEnd) begin
                    tx_d     = shift_q[0];
                    shift_d  = shift_q >> 1;
                    bitIdx_d = 3'd0;
                end
            end
            DATA: begin
                if (bitEnd) begin
                    shift_d = shift_q >> 1;
                    if (bitIdx_q == 3'd7) begin
                        stopIdx_d = 1'b0;
                        tx_d      = (PARITY_EN != 0) ? parity_q : 1'b1;
                    end else begin
                        tx_d     = shift_q[0];
                        bitIdx_d = bitIdx_q + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (bitEnd) begin
                    tx_d      = 1'b1;
                    stopIdx_d = 1'b0;
                end
            end
            STOP: begin
                if (bitEnd) begin
                    if (lastStop) begin
                        busy_d = 1'b0;
                        done_d = 1'b1;
                    end else begin
                        stopIdx_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase

        // Parity is taken from the byte as latched, since shifting consumes it.
        if (accept) begin
            baudCnt_d = '0;
            bitIdx_d  = 3'd0;
            stopIdx_d = 1'b0;
            shift_d   = urt_tx_data;
            parity_d  = (^urt_tx_data) ^ ODD_FLIP;
            tx_d      = 1'b0;
            busy_d    = 1'b1;
        end
    end

    assign busy_uart = busy_q;
    assign tx        = tx_q;
    assign tx_done   = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: four instances cover the default frame,
// even/odd parity and two stop bits; expected frames are hand-written bit patterns.
module tb_uart_tx_serializer;

    logic       systemClock;
    logic       rst;

    logic       start0, startPar, startStop;
    logic [7:0] data0, dataPar, dataStop;
    logic       busy0, tx0, done0;
    logic       busyEven, txEven, doneEven;
    logic       busyOdd, txOdd, doneOdd;
    logic       busyStop, txStop, doneStop;

    int compared;
    int mismatched;

    uart_tx_serializer #(.CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut0 (
        .system_clock(systemClock), .rst(rst), .start_uart(start0), .urt_tx_data(data0),
        .busy_uart(busy0), .tx(tx0), .tx_done(done0));

    uart_tx_serializer #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dutEven (
        .system_clock(systemClock), .rst(rst), .start_uart(startPar), .urt_tx_data(dataPar),
        .busy_uart(busyEven), .tx(txEven), .tx_done(doneEven));

    uart_tx_serializer #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dutOdd (
        .system_clock(systemClock), .rst(rst), .start_uart(startPar), .urt_tx_data(dataPar),
        .busy_uart(busyOdd), .tx(txOdd), .tx_done(doneOdd));

    uart_tx_serializer #(.CLKS_PER_BIT(2), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) dutStop (
        .system_clock(systemClock), .rst(rst), .start_uart(startStop), .urt_tx_data(dataStop),
        .busy_uart(busyStop), .tx(txStop), .tx_done(doneStop));

    initial systemClock = 1'b0;
    always #5 systemClock = ~systemClock;

    task automatic tick();
        @(posedge systemClock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic observed, input logic expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic [7:0] d);
        start0 = s;
        data0  = d;
    endtask

    task automatic checkState0(input string tag, input logic expTx, input logic expBusy, input logic expDone);
        checkOutput({tag, ".tx"}, tx0, expTx);
        checkOutput({tag, ".busy"}, busy0, expBusy);
        checkOutput({tag, ".done"}, done0, expDone);
    endtask

    // pat[k] is the expected line level of bit slot k (slot 0 = start bit).
    task automatic checkFrame0(input logic [11:0] pat, input int cycles, input int pokeAt, input string tag);
        for (int i = 0; i < cycles; i++) begin
            checkOutput($sformatf("%s.tx[%0d]", tag, i), tx0, pat[i / 4]);
            checkOutput($sformatf("%s.busy[%0d]", tag, i), busy0, 1'b1);
            if (i > 0) begin
                checkOutput($sformatf("%s.done[%0d]", tag, i), done0, 1'b0);
            end
            if (pokeAt >= 0 && i == pokeAt) begin
                applyStimulus(1'b1, 8'h00);
            end else if (pokeAt >= 0 && i == pokeAt + 1) begin
                applyStimulus(1'b0, 8'h00);
            end
            tick();
        end
    endtask

    initial begin
        logic [11:0] patEven;
        logic [11:0] patOdd;
        logic [11:0] patStop;

        compared   = 0;
        mismatched = 0;
        rst        = 1'b1;
        applyStimulus(1'b0, 8'h00);
        startPar   = 1'b0;
        dataPar    = 8'h00;
        startStop  = 1'b0;
        dataStop   = 8'h00;

        tick();
        tick();
        checkState0("reset0", 1'b1, 1'b0, 1'b0);
        checkOutput("resetStop.tx", txStop, 1'b1);
        checkOutput("resetStop.busy", busyStop, 1'b0);
        rst = 1'b0;
        tick();
        checkState0("idle0", 1'b1, 1'b0, 1'b0);

        $display("[TB] single byte 0x55");
        applyStimulus(1'b1, 8'h55);
        tick();
        applyStimulus(1'b0, 8'h55);
        checkFrame0(12'b00_1010101010, 40, -1, "f55");
        checkState0("f55.end", 1'b1, 1'b0, 1'b1);
        tick();
        checkState0("f55.after", 1'b1, 1'b0, 1'b0);

        $display("[TB] back-to-back 0xA3 then 0x0D");
        applyStimulus(1'b1, 8'hA3);
        tick();
        applyStimulus(1'b1, 8'h0D);
        checkFrame0(12'b00_1101000110, 40, -1, "fA3");
        checkState0("fA3.end", 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 8'h0D);
        checkFrame0(12'b00_1000011010, 40, -1, "f0D");
        checkState0("f0D.end", 1'b1, 1'b0, 1'b1);
        tick();
        checkState0("f0D.after", 1'b1, 1'b0, 1'b0);

        $display("[TB] start while busy, 0xFF");
        applyStimulus(1'b1, 8'hFF);
        tick();
        applyStimulus(1'b0, 8'hFF);
        checkFrame0(12'b00_1111111110, 40, 11, "fFF");
        checkState0("fFF.end", 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkState0($sformatf("fFF.idle%0d", i), 1'b1, 1'b0, 1'b0);
        end

        $display("[TB] reset mid-frame 0x20, then 0x0A");
        applyStimulus(1'b1, 8'h20);
        tick();
        applyStimulus(1'b0, 8'h20);
        checkFrame0(12'b00_1001000000, 16, -1, "f20");
        rst = 1'b1;
        applyStimulus(1'b1, 8'h0A);
        tick();
        checkState0("f20.rst", 1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        checkState0("f0A.accept", 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h0A);
        checkFrame0(12'b00_1000010100, 40, -1, "f0A");
        checkState0("f0A.end", 1'b1, 1'b0, 1'b1);

        $display("[TB] parity 0x07 even/odd");
        patEven = 12'b0_11000001110;
        patOdd  = 12'b0_10000001110;
        startPar = 1'b1;
        dataPar  = 8'h07;
        tick();
        startPar = 1'b0;
        dataPar  = 8'hF8;
        for (int i = 0; i < 44; i++) begin
            checkOutput($sformatf("parEven.tx[%0d]", i), txEven, patEven[i / 4]);
            checkOutput($sformatf("parOdd.tx[%0d]", i), txOdd, patOdd[i / 4]);
            checkOutput($sformatf("parEven.busy[%0d]", i), busyEven, 1'b1);
            checkOutput($sformatf("parOdd.busy[%0d]", i), busyOdd, 1'b1);
            tick();
        end
        checkOutput("parEven.endBusy", busyEven, 1'b0);
        checkOutput("parEven.endDone", doneEven, 1'b1);
        checkOutput("parOdd.endBusy", busyOdd, 1'b0);
        checkOutput("parOdd.endDone", doneOdd, 1'b1);

        $display("[TB] two stop bits, 0x00, 2 clocks per bit");
        patStop   = 12'b0_11000000000;
        startStop = 1'b1;
        dataStop  = 8'h00;
        tick();
        startStop = 1'b0;
        for (int i = 0; i < 22; i++) begin
            checkOutput($sformatf("stop2.tx[%0d]", i), txStop, patStop[i / 2]);
            checkOutput($sformatf("stop2.busy[%0d]", i), busyStop, 1'b1);
            checkOutput($sformatf("stop2.done[%0d]", i), doneStop, 1'b0);
            tick();
        end
        checkOutput("stop2.endBusy", busyStop, 1'b0);
        checkOutput("stop2.endDone", doneStop, 1'b1);
        checkOutput("stop2.endTx", txStop, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/uart_tx_serializer.md
UART_TX_SERIALIZER -- requirements
Module: uart_tx_serializer

Interface
REQ-001 The block SHALL use one clock and one reset: system_clock; reset is synchronous and active-high, named rst.
REQ-002 Parameters SHALL be, one per line:
- CLKS_PER_BIT, default 868, system_clock cycles per serial bit; legal range 2..65535.
- PARITY_EN, default 0, 1 = append a parity bit after the data bits.
- PARITY_ODD, default 0, 1 = odd parity, 0 = even parity; ignored when PARITY_EN=0.
- STOP_BITS, default 1, number of stop bits; legal values 1 or 2.
REQ-003 Ports SHALL be, one per line:
- system_clock  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- start_uart  in  1  level request; sampled only while idle.
- urt_tx_data  in  8  byte to send; sampled on the accepting edge.
- busy_uart  out  1  registered; high from acceptance until the last stop bit completes.
- tx  out  1  registered serial line; idle high.
- tx_done  out  1  registered one-cycle pulse at frame end.

Function
REQ-004 The state machine SHALL have states IDLE, START_BIT, DATA, PARITY, STOP, with transitions:
- IDLE->START_BIT: on any edge where start_uart=1.
- START_BIT->DATA: after CLKS_PER_BIT cycles.
- DATA->PARITY when PARITY_EN=1, else DATA->STOP: after 8 bits.
- PARITY->STOP: after CLKS_PER_BIT cycles.
- STOP->IDLE: after STOP_BITS*CLKS_PER_BIT cycles.
REQ-005 On the accepting edge the block SHALL latch urt_tx_data into a shift register, set busy_uart=1 and drive tx=0, all visible in the very next cycle (zero-cycle latency from the sampled request to the start bit).
REQ-006 busy_uart SHALL already be 1 in the cycle immediately after start_uart is sampled high; an upstream stage that drops start_uart after one cycle and then polls busy_uart relies on this.
REQ-007 Each bit SHALL be held on tx for exactly CLKS_PER_BIT cycles.
- A baud counter of width $clog2(CLKS_PER_BIT) SHALL run from 0 to CLKS_PER_BIT-1 and wrap to 0 at each bit boundary.
- A 3-bit bit index SHALL count data bits 0..7.
REQ-008 Data bits SHALL be sent LSB first; the shift register SHALL shift right once per bit boundary.
REQ-009 The parity bit SHALL be the XOR of the 8 latched data bits, inverted when PARITY_ODD=1.
REQ-010 Stop bits SHALL drive tx=1.
REQ-011 On the final stop-bit cycle boundary the block SHALL do the following on the same edge:
- enter IDLE;
- clear busy_uart;
- pulse tx_done for exactly one cycle.
REQ-012 Total frame length SHALL be (1+8+PARITY_EN+STOP_BITS)*CLKS_PER_BIT cycles, measured from the first tx=0 cycle to the first cycle with busy_uart=0.
REQ-013 start_uart=1 while busy_uart=1 SHALL be ignored; no queuing, and the in-flight frame and latched data SHALL remain unaffected.
REQ-014 If start_uart=1 in the cycle busy_uart falls, the block SHALL accept that request on that edge.
- Back-to-back frames SHALL have no idle gap beyond the stop bits.
- tx_done and the new busy_uart=1 SHALL be coincident for that one cycle.
REQ-015 urt_tx_data changes after the accepting edge SHALL NOT alter the frame being sent.

Reset
REQ-016 While rst=1 at a rising edge, the block SHALL set the following, overriding any in-flight frame:
- state=IDLE;
- tx=1;
- busy_uart=0;
- tx_done=0;
- counters=0;
- shift register=0.
REQ-017 A start_uart sampled on the same edge as rst=1 SHALL be discarded.
REQ-018 After rst deasserts, the first accept SHALL be possible on the next edge.

Verification (CLKS_PER_BIT=4 unless stated)
REQ-019 The bench SHALL cover these directed scenarios:
- Single byte: start_uart pulse for 1 cycle with 0x55 -> tx = 0,1,0,1,0,1,0,1,0,1, each held 4 cycles; busy high for 40 cycles; tx_done pulses once, coincident with busy falling.
- Back-to-back: start_uart held high with 0xA3 then 0x0D -> both frames complete, no gap between stop bit and next start bit; tx_done pulses twice.
- Start while busy: second start_uart pulse at cycle 12 of a 0xFF frame -> ignored; frame bits unchanged; busy stays low after frame end.
- Parity: PARITY_EN=1, PARITY_ODD=0, byte 0x07 -> parity bit 1; with PARITY_ODD=1 -> 0; frame 44 cycles.
- Reset mid-frame: rst=1 at cycle 17 of a 0x20 frame -> next cycle tx=1, busy_uart=0, no tx_done; new 0x0A frame accepted right after rst deasserts.
- STOP_BITS=2, CLKS_PER_BIT=2, byte 0x00 -> tx low 18 cycles, then high 4 cycles before busy_uart falls.
